mul_unit: RTL and testbench
===========================

# mul_unit

Iterative multiply / multiply-accumulate execution unit for the ARM core. It consumes the `rm_out`, `rs_out` and `rn_out` operands read from the register file and computes `Rd = Rm*Rs` (MUL) or `Rd = Rm*Rs + Rn` (MLA). It returns the low WORD_SIZE bits to the register-file write port (`rd_in`, `write_rd`, `rd_we`) and, for the S variants, new N/Z flags to `cpsr_in`/`cpsr_we`. While it runs it holds `busy` high, and the control path uses `busy` to hold the PC (`pc_we`) and the issue of the next instruction.

## Interface
- `WORD_SIZE`, 32: operand and result width.
- `ADDR_WIDTH`, 4: register address width.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request a multiply; accepted only in IDLE.
- `accumulate`  in  1: 1 = MLA (add Rn), 0 = MUL.
- `set_flags`  in  1: S bit; update N/Z on completion.
- `rd_addr`  in  ADDR_WIDTH: destination register.
- `rm_in`  in  WORD_SIZE: multiplicand (Rm).
- `rs_in`  in  WORD_SIZE: multiplier (Rs).
- `rn_in`  in  WORD_SIZE: accumulate operand (Rn).
- `cpsr_in`  in  WORD_SIZE: current CPSR; supplies the preserved bits.
- `busy`  out  1: high in RUN and DONE.
- `rd_we`  out  1: one-cycle write strobe (done).
- `write_rd`  out  ADDR_WIDTH: latched destination address.
- `rd_out`  out  WORD_SIZE: result.
- `cpsr_we`  out  1: one-cycle flag-write strobe.
- `cpsr_out`  out  WORD_SIZE: `{N, Z, cpsr[29:0]}`.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE, `start`=1:**
  - Load `acc` = `accumulate` ? `rn_in` : 0; `mcand` = `rm_in`; `mplier` = `rs_in`.
  - Latch `rd_addr`, `set_flags`, and `cpsr_in[29:0]`.
  - Go to RUN.
- **IDLE, `start`=0:** stay in IDLE.
- **RUN, each cycle:**
  - If `mplier[0]`, `acc` += `mcand` (mod 2^WORD_SIZE).
  - `mcand` <<= 1; `mplier` >>= 1 (logical).
  - Go to DONE when the shifted `mplier` is 0, otherwise stay in RUN.
- **RUN length (early termination):** k = max(1, msb_index(Rs)+1) cycles, where 1 ≤ k ≤ WORD_SIZE. Rs = 0 still takes exactly 1 RUN cycle with no add.
- **DONE, exactly one cycle:**
  - `rd_we`=1, with `rd_out`=`acc` and `write_rd`=latched address.
  - `cpsr_we` = latched `set_flags`.
  - `cpsr_out` = {`acc[WORD_SIZE-1]`, (`acc`==0), latched `cpsr[29:0]`]. C and V are preserved from `cpsr_in` as sampled at start.
  - Then go to IDLE.
- **Arithmetic:** only the low WORD_SIZE bits of the product are kept. Overflow wraps silently, and the result is identical for signed and unsigned operands.
- **`start` while `busy`:** ignored, not queued. The operands on those cycles have no effect.
- **Input sampling:** inputs are sampled only on the accepting edge and may change freely afterwards.
- **`rd_addr` = 15:** written like any other register. The control path must hold `pc_we` consistently.

## Timing
- **Reset values:** state IDLE; `busy`=0, `rd_we`=0, `cpsr_we`=0, `rd_out`=0, `write_rd`=0, `cpsr_out`=0, and all internal registers 0.
- **Reset mid-RUN or mid-DONE:** abort to IDLE at that edge. No `rd_we` or `cpsr_we` is issued, including when reset coincides with DONE.
- **Cycle numbering:** `start` is sampled at edge 0.
  - `busy`=1 from cycle 1.
  - RUN occupies cycles 1..k.
  - DONE is cycle k+1: `rd_we` high, and the register file writes at edge k+1.
  - `busy`=0 from cycle k+2.
  - A new `start` is accepted at the earliest at edge k+2; there is no back-to-back acceptance at the DONE edge.
- **Strobes:** `rd_we` and `cpsr_we` are each high for exactly one cycle per operation. `rd_out` and `cpsr_out` hold their values until the next DONE or a reset.
- **Throughput:** one operation per k+2 cycles.

## Test plan
- **MUL basic:** Rm=7, Rs=6, rd=3, S=0 → k=3; `rd_we` pulses in cycle 4 with `rd_out`=42, `write_rd`=3; `cpsr_we`=0.
- **MLA with zero multiplier:** Rm=0x1234, Rs=0, Rn=5, S=1 → k=1; `rd_out`=5 in cycle 2; `cpsr_we`=1 with N=0, Z=0. The same operation with MUL gives `rd_out`=0 and Z=1.
- **Wrap and full length:** Rm=Rs=0xFFFFFFFF → k=32; `rd_out`=0x00000001 in cycle 33; `busy` high for exactly 33 cycles.
- **Flags:** Rm=0x40000000, Rs=2, S=1, `cpsr_in`=0x3000001F → `rd_out`=0x80000000, `cpsr_out`=0xB000001F.
- **Start while busy:** a second `start` with different operands during RUN → ignored; only the first result is written, and there is a single `rd_we` pulse.
- **Reset mid-RUN:** assert `reset` in cycle 2 of a 32-cycle operation → `busy`=0 from the next cycle; no `rd_we` or `cpsr_we` ever asserted; a following MUL 3×3 returns 9.

Source files
------------

// File: rtl/mul_unit_if.sv
// Bundle between the control path and the iterative multiply unit:
// operand/request inputs plus the register-file and CPSR write-back outputs.
interface mul_unit_if #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic                  accumulate;
  logic                  set_flags;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [WORD_SIZE-1:0]  rm_in;
  logic [WORD_SIZE-1:0]  rs_in;
  logic [WORD_SIZE-1:0]  rn_in;
  logic [WORD_SIZE-1:0]  cpsr_in;
  logic                  busy;
  logic                  rd_we;
  logic [ADDR_WIDTH-1:0] write_rd;
  logic [WORD_SIZE-1:0]  rd_out;
  logic                  cpsr_we;
  logic [WORD_SIZE-1:0]  cpsr_out;

  // Request/acknowledge: start is taken only on an edge where busy is low;
  // there is no backpressure on the result, rd_we/cpsr_we are single-cycle strobes.
  modport master (
    output start, accumulate, set_flags, rd_addr, rm_in, rs_in, rn_in, cpsr_in,
    input  busy, rd_we, write_rd, rd_out, cpsr_we, cpsr_out
  );

  modport slave (
    input  start, accumulate, set_flags, rd_addr, rm_in, rs_in, rn_in, cpsr_in,
    output busy, rd_we, write_rd, rd_out, cpsr_we, cpsr_out
  );
endinterface

// File: rtl/mul_unit.sv
// Shift-and-add MUL/MLA unit with early termination on the multiplier's
// most significant set bit; results are written back through one-cycle strobes.
module mul_unit #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  mul_unit_if.slave  bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WORD_SIZE-1:0]  acc;
  logic [WORD_SIZE-1:0]  mcand;
  logic [WORD_SIZE-1:0]  mplier;
  logic [ADDR_WIDTH-1:0] rd_lat;
  logic                  sf_lat;
  logic [WORD_SIZE-3:0]  cpsr_lat;

  logic [ADDR_WIDTH-1:0] write_rd_q;
  logic [WORD_SIZE-1:0]  rd_out_q;
  logic [WORD_SIZE-1:0]  cpsr_out_q;

  logic [WORD_SIZE-1:0]  acc_step;
  logic [WORD_SIZE-1:0]  mplier_sh;
  logic                  last_step;

  always_comb begin
    acc_step   = acc + (mplier[0] ? mcand : '0);
    mplier_sh  = mplier >> 1;
    last_step  = (mplier_sh == '0);
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      rd_lat     <= '0;
      sf_lat     <= 1'b0;
      cpsr_lat   <= '0;
      write_rd_q <= '0;
      rd_out_q   <= '0;
      cpsr_out_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc      <= bus.accumulate ? bus.rn_in : '0;
            mcand    <= bus.rm_in;
            mplier   <= bus.rs_in;
            rd_lat   <= bus.rd_addr;
            sf_lat   <= bus.set_flags;
            cpsr_lat <= bus.cpsr_in[WORD_SIZE-3:0];
          end
        end
        RUN: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier_sh;
          // Result registers update only here so they hold until the next DONE.
          if (last_step) begin
            rd_out_q   <= acc_step;
            write_rd_q <= rd_lat;
            cpsr_out_q <= {acc_step[WORD_SIZE-1], (acc_step == '0), cpsr_lat};
          end
        end
        default: ;
      endcase
    end
  end

  // Reset on the DONE edge suppresses the write-back strobes.
  assign bus.busy     = (state != IDLE);
  assign bus.rd_we    = (state == DONE) && !reset;
  assign bus.cpsr_we  = (state == DONE) && sf_lat && !reset;
  assign bus.rd_out   = rd_out_q;
  assign bus.write_rd = write_rd_q;
  assign bus.cpsr_out = cpsr_out_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_mul_unit.sv
// Randomized and directed bench for mul_unit: a driver pushes model results
// into an expected queue and a monitor checks every write-back strobe.
module tb_mul_unit;

  localparam int W = 32;
  localparam int A = 4;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  mul_unit_if #(.WORD_SIZE(W), .ADDR_WIDTH(A)) bus ();

  mul_unit #(.WORD_SIZE(W), .ADDR_WIDTH(A)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [W-1:0] rd;
    logic [A-1:0] addr;
    logic         cpsr_we;
    logic [W-1:0] cpsr;
    logic [31:0]  done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic int run_len(input logic [W-1:0] rs);
    int k = 1;
    for (int i = 0; i < W; i++) if (rs[i]) k = i + 1;
    return k;
  endfunction

  function automatic exp_t model(input logic [W-1:0] rm, rs, rn, cpsr,
                                 input logic acc, sf, input logic [A-1:0] rd,
                                 input logic [31:0] start_edge_cyc);
    exp_t e;
    logic [63:0]  full;
    logic [W-1:0] res;
    full = 64'(rm) * 64'(rs) + (acc ? 64'(rn) : 64'd0);
    res  = full[W-1:0];
    e.rd       = res;
    e.addr     = rd;
    e.cpsr_we  = sf;
    e.cpsr     = (res[W-1] ? 32'h8000_0000 : 32'h0) | ((res == 0) ? 32'h4000_0000 : 32'h0)
                 | (cpsr & 32'h3FFF_FFFF);
    e.done_cyc = start_edge_cyc + 32'(run_len(rs));
    return e;
  endfunction

  // ---------------- monitor ----------------
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (bus.cpsr_we && !bus.rd_we) fail_now("cpsr_we_without_rd_we");
    if (bus.rd_we) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_rd_we");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_out",   64'(bus.rd_out),   64'(e.rd));
        chk("write_rd", 64'(bus.write_rd), 64'(e.addr));
        chk("cpsr_we",  64'(bus.cpsr_we),  64'(e.cpsr_we));
        chk("cpsr_out", 64'(bus.cpsr_out), 64'(e.cpsr));
        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic scramble_inputs();
    bus.accumulate = 1'($urandom);
    bus.set_flags  = 1'($urandom);
    bus.rd_addr    = A'($urandom);
    bus.rm_in      = $urandom;
    bus.rs_in      = $urandom;
    bus.rn_in      = $urandom;
    bus.cpsr_in    = $urandom;
  endtask

  task automatic issue(input logic [W-1:0] rm, rs, rn, cpsr,
                       input logic acc, sf, input logic [A-1:0] rd, input bit expect_result);
    int guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (bus.busy) fail_now("issue_wait_timeout");
    bus.start      = 1'b1;
    bus.accumulate = acc;
    bus.set_flags  = sf;
    bus.rd_addr    = rd;
    bus.rm_in      = rm;
    bus.rs_in      = rs;
    bus.rn_in      = rn;
    bus.cpsr_in    = cpsr;
    if (expect_result) exp_q.push_back(model(rm, rs, rn, cpsr, acc, sf, rd, 32'(cyc + 1)));
    @(negedge clk);
    bus.start = 1'b0;
    scramble_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int guard;
    logic [W-1:0] rs;

    reset     = 1'b1;
    bus.start = 1'b0;
    scramble_inputs();
    repeat (3) @(negedge clk);
    chk("reset_busy",     64'(bus.busy),     64'd0);
    chk("reset_rd_we",    64'(bus.rd_we),    64'd0);
    chk("reset_cpsr_we",  64'(bus.cpsr_we),  64'd0);
    chk("reset_rd_out",   64'(bus.rd_out),   64'd0);
    chk("reset_write_rd", 64'(bus.write_rd), 64'd0);
    chk("reset_cpsr_out", 64'(bus.cpsr_out), 64'd0);
    reset = 1'b0;
    idle(2);

    // Directed cases
    issue(32'd7, 32'd6, 32'd0, 32'h0, 1'b0, 1'b0, 4'd3, 1'b1);
    issue(32'h1234, 32'd0, 32'd5, 32'h0, 1'b1, 1'b1, 4'd4, 1'b1);
    issue(32'h1234, 32'd0, 32'd5, 32'h0, 1'b0, 1'b1, 4'd5, 1'b1);
    issue(32'h4000_0000, 32'd2, 32'd0, 32'h3000_001F, 1'b0, 1'b1, 4'd15, 1'b1);

    // Full-length wrap; busy must stay high for exactly 33 cycles
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hC000_0000, 1'b0, 1'b1, 4'd7, 1'b1);
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("wrap_busy_cycles", 64'(cnt), 64'd33);

    // Start while busy is ignored
    issue(32'd1000, 32'h0000_FFFF, 32'd1, 32'h0, 1'b1, 1'b0, 4'd2, 1'b1);
    idle(2);
    bus.start   = 1'b1;
    bus.rm_in   = 32'd9;
    bus.rs_in   = 32'd9;
    bus.rd_addr = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    idle(20);

    // Reset in cycle 2 of a 32-cycle operation
    issue(32'd77, 32'h8000_0001, 32'd0, 32'h0, 1'b0, 1'b1, 4'd6, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_abort_busy", 64'(bus.busy), 64'd0);
    idle(40);
    issue(32'd3, 32'd3, 32'd0, 32'h0, 1'b0, 1'b0, 4'd1, 1'b1);

    // Randomized operations with varying multiplier widths and gaps
    for (int i = 0; i < 40; i++) begin
      rs = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) rs = '0;
      issue($urandom, rs, $urandom, $urandom, 1'($urandom), 1'($urandom), A'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    idle(5);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
